// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED constants for the water-light shifter and its PWM trail stage
// Default channel count, PWM width and the shifter's one-hot start pattern.
package led_pkg;

   localparam int N_LED    = 4;
   localparam int PWM_BITS = 8;
   localparam int LED_MAX  = (1 << PWM_BITS) - 1;

   localparam logic [N_LED-1:0] LED_RESET_PATTERN = 4'b0001;

   // Full-brightness level for an arbitrary PWM width.
   function automatic int led_max(input int bits);
      return (1 << bits) - 1;
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED channel: brightness level with linear decay, period-latched duty, PWM output
// Level jumps to full on led_in, fades on decay ticks; duty only changes at the period boundary.
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS   = led_pkg::PWM_BITS,
   parameter int DECAY_STEP = 8
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                en,
   input  logic                led_in,
   input  logic                decay_tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led_out
);

   localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(led_max(PWM_BITS));
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

   logic [PWM_BITS-1:0] level_q, level_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                led_out_q, led_out_d;

   always_comb begin
      level_d   = level_q;
      duty_d    = duty_q;
      led_out_d = 1'b0;
      if (!en) begin
         level_d = '0;
         duty_d  = '0;
      end else begin
         if (led_in) begin
            level_d = MAX;
         end else if (decay_tick) begin
            // Saturate at dark so a fading LED never wraps back to bright.
            level_d = (level_q >= STEP) ? level_q - STEP : '0;
         end
         if (pwm_cnt == MAX) begin
            duty_d = level_q;
         end
         // Full duty is forced high so a lit LED has no one-cycle gap per period.
         led_out_d = (duty_q == MAX) ? 1'b1 : (pwm_cnt < duty_q);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         level_q   <= '0;
         duty_q    <= '0;
         led_out_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         duty_q    <= duty_d;
         led_out_q <= led_out_d;
      end
   end

   assign led_out = led_out_q;

endmodule

// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - PWM comet-trail driver between the LED shifter and the LED pins
// Shared PWM period counter, decay-tick divider and sync probe; one channel per LED.
module led_trail_pwm #(
   parameter int N_LED      = led_pkg::N_LED,
   parameter int PWM_BITS   = led_pkg::PWM_BITS,
   parameter int DECAY_DIV  = 195312,
   parameter int DECAY_STEP = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             en,
   input  logic [N_LED-1:0] led_in,
   output logic [N_LED-1:0] led_out,
   output logic             pwm_sync
);

   localparam int                DC_W     = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [DC_W-1:0]   DIV_LAST = DC_W'(DECAY_DIV - 1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [DC_W-1:0]     decay_cnt_q, decay_cnt_d;
   logic                pwm_sync_q, pwm_sync_d;
   logic                decay_tick;

   assign decay_tick = (decay_cnt_q == DIV_LAST);

   always_comb begin
      pwm_cnt_d   = '0;
      decay_cnt_d = '0;
      pwm_sync_d  = 1'b0;
      if (en) begin
         // The PWM counter wraps naturally at 2**PWM_BITS.
         pwm_cnt_d   = pwm_cnt_q + 1'b1;
         decay_cnt_d = decay_tick ? '0 : decay_cnt_q + 1'b1;
         pwm_sync_d  = (pwm_cnt_q == '0);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pwm_cnt_q   <= '0;
         decay_cnt_q <= '0;
         pwm_sync_q  <= 1'b0;
      end else begin
         pwm_cnt_q   <= pwm_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         pwm_sync_q  <= pwm_sync_d;
      end
   end

   assign pwm_sync = pwm_sync_q;

   for (genvar i = 0; i < N_LED; i++) begin : g_chan
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_chan (
         .sys_clk    (sys_clk),
         .sys_rst    (sys_rst),
         .en         (en),
         .led_in     (led_in[i]),
         .decay_tick (decay_tick),
         .pwm_cnt    (pwm_cnt_q),
         .led_out    (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb/tb_led_trail_pwm.sv - self-checking bench for led_trail_pwm against a period/level reference model
// Small parameters: 16-cycle PWM period, decay tick every 4 clocks, step 4.
module tb_led_trail_pwm;

   localparam int MAXV = 15;
   localparam int PER  = 16;
   localparam int DIV  = 4;
   localparam int STEP = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] led_in = 4'b0000;
   logic [3:0] led_out;
   logic       pwm_sync;

   int vectors = 0;
   int miscompares = 0;

   // Reference: time since enable, per-channel brightness and latched duty.
   int         t;
   int         lvl [4];
   int         dty [4];
   logic [3:0] eo;
   logic       es;

   led_trail_pwm #(
      .N_LED      (4),
      .PWM_BITS   (4),
      .DECAY_DIV  (DIV),
      .DECAY_STEP (STEP)
   ) dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .en       (en),
      .led_in   (led_in),
      .led_out  (led_out),
      .pwm_sync (pwm_sync)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      t  = 0;
      eo = '0;
      es = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lvl[i] = 0;
         dty[i] = 0;
      end
   endtask

   task automatic model_edge();
      int ph;
      bit tick;
      if (rst || !en) begin
         model_clear();
      end else begin
         ph   = t % PER;
         tick = ((t % DIV) == DIV - 1);
         for (int i = 0; i < 4; i++) eo[i] = (dty[i] == MAXV) || (ph < dty[i]);
         es = (ph == 0);
         if (ph == PER - 1) for (int i = 0; i < 4; i++) dty[i] = lvl[i];
         for (int i = 0; i < 4; i++) begin
            if (led_in[i]) lvl[i] = MAXV;
            else if (tick) lvl[i] = (lvl[i] >= STEP) ? lvl[i] - STEP : 0;
         end
         t++;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("led_out", led_out, eo);
      check("pwm_sync", pwm_sync, es);
      @(negedge clk);
   endtask

   // Waits for the next period start, then counts high cycles of one channel over a full period.
   task automatic period_count(input int ch, output int cnt);
      int guard;
      int exp_cnt;
      guard = 0;
      while (pwm_sync !== 1'b1 && guard < 40) begin
         step();
         guard++;
      end
      check("sync_wait", pwm_sync, 1);
      exp_cnt = (dty[ch] == MAXV) ? PER : dty[ch];
      cnt = led_out[ch];
      for (int k = 0; k < PER - 1; k++) begin
         step();
         cnt += led_out[ch];
      end
      check("period_cnt", cnt, exp_cnt);
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      check("rst_led_out", led_out, 0);
      check("rst_pwm_sync", pwm_sync, 0);
      model_clear();
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_hold_out", led_out, 0);
         @(negedge clk);
      end
      rst = 1'b0;
      step();
      check("first_sync", pwm_sync, 1);
   endtask

   initial begin
      int cnt;
      int prev;
      int guard;
      model_clear();
      repeat (2) @(negedge clk);
      check("reset_out", led_out, 0);
      check("reset_sync", pwm_sync, 0);

      // Release from reset, running.
      rst = 1'b0;
      en  = 1'b1;
      step();
      check("first_sync_boot", pwm_sync, 1);

      // Held LED 0: full-on from the second period.
      led_in = 4'b0001;
      repeat (3) period_count(0, cnt);
      check("full_on", cnt, PER);

      // Release: trail fades to dark and stays there.
      led_in = 4'b0000;
      prev = PER;
      for (int p = 0; p < 4; p++) begin
         period_count(0, cnt);
         check("fade_monotonic", (cnt <= prev), 1);
         prev = cnt;
      end
      check("fade_dark", cnt, 0);

      // Reset in the middle of a fade while the output is still lit.
      led_in = 4'b0001;
      repeat (2) period_count(0, cnt);
      led_in = 4'b0000;
      repeat (8) step();
      async_reset();

      // LED 1 rises on a decay-tick cycle late in a period.
      guard = 0;
      while (!((t % PER) == 11) && guard < 40) begin
         step();
         guard++;
      end
      check("tick_align", (t % DIV), DIV - 1);
      led_in = 4'b0010;
      period_count(1, cnt);
      check("tick_rise_full", cnt, PER);
      led_in = 4'b0000;

      // Shifter-style sweep, then watch the last channel's trail.
      for (int k = 0; k < 4; k++) begin
         led_in = 4'(1 << k);
         repeat (PER) step();
      end
      led_in = 4'b0000;
      prev = PER;
      for (int p = 0; p < 3; p++) begin
         period_count(3, cnt);
         check("sweep_monotonic", (cnt <= prev), 1);
         prev = cnt;
      end

      // Drop en mid-period with everything lit.
      led_in = 4'b1111;
      repeat (2) period_count(2, cnt);
      repeat (7) step();
      en = 1'b0;
      step();
      check("en_off_out", led_out, 0);
      repeat (3) step();
      en = 1'b1;
      step();
      check("en_resync", pwm_sync, 1);
      led_in = 4'b0000;

      // Randomized traffic with occasional enable drops.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) led_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) en = ~en;
         step();
      end
      en = 1'b1;
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
